pc_interface_read_ctrl: RTL

- Downstream consumer of the PC interface read bank.
- On a read request from the command decoder, it drives the bank address and captures the selected word one cycle later.
- It then serializes the word into a byte frame on a valid/ready stream towards the UART transmitter: optional header, data bytes MSB-first, XOR checksum.
- It sits between the read bank and the UART TX FIFO/transmitter.

---
 rtl/pc_interface_pkg.sv | 30 +++
 rtl/pc_interface_tx_shift.sv | 64 ++++++
 rtl/pc_interface_read_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_interface_pkg.sv
// Shared definitions for the PC interface read path: byte width, default header
// and the read-controller state encoding.
package pc_interface_pkg;

    localparam int unsigned PC_IF_BYTE_W  = 8;
    localparam int unsigned PC_IF_STATE_W = 3;

    localparam logic [PC_IF_BYTE_W-1:0] PC_IF_HEADER_DEFAULT = 8'hA5;

    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_IDLE    = 3'd0;
    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_CAPTURE = 3'd1;
    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_HEADER  = 3'd2;
    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_DATA    = 3'd3;
    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_CHKSUM  = 3'd4;
    localparam logic [PC_IF_STATE_W-1:0] PC_IF_ST_DONE    = 3'd5;

    typedef enum logic [PC_IF_STATE_W-1:0] {
        ST_IDLE    = PC_IF_ST_IDLE,
        ST_CAPTURE = PC_IF_ST_CAPTURE,
        ST_HEADER  = PC_IF_ST_HEADER,
        ST_DATA    = PC_IF_ST_DATA,
        ST_CHKSUM  = PC_IF_ST_CHKSUM,
        ST_DONE    = PC_IF_ST_DONE
    } pc_if_state_e;

    function automatic int unsigned pc_if_num_bytes(input int unsigned data_width);
        return data_width / PC_IF_BYTE_W;
    endfunction

endpackage

// File: rtl/pc_interface_tx_shift.sv
// Word-to-byte serializer: parallel load, MSB-first byte shift on each advance,
// running XOR checksum and a last-byte flag.
module pc_interface_tx_shift
    import pc_interface_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    load_i,
    input  logic [DATA_WIDTH-1:0]   word_i,
    input  logic [PC_IF_BYTE_W-1:0] chk_init_i,
    input  logic                    shift_i,
    output logic [PC_IF_BYTE_W-1:0] byte_o,
    output logic [PC_IF_BYTE_W-1:0] next_byte_o,
    output logic [PC_IF_BYTE_W-1:0] chk_next_o,
    output logic                    last_o
);

    localparam int unsigned NUM_BYTES = pc_if_num_bytes(DATA_WIDTH);
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);

    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PC_IF_BYTE_W-1:0] chk_q, chk_d;

    assign byte_o = shift_q[DATA_WIDTH-1 -: PC_IF_BYTE_W];

    // Load wins over shift; the counter parks at zero on the last byte.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = CNT_W'(NUM_BYTES - 1);
            chk_d   = chk_init_i;
        end else if (shift_i) begin
            shift_d = shift_q << PC_IF_BYTE_W;
            chk_d   = chk_q ^ byte_o;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Look-ahead views let the parent register its byte output without a bubble.
    assign next_byte_o = shift_d[DATA_WIDTH-1 -: PC_IF_BYTE_W];
    assign chk_next_o  = chk_d;
    assign last_o      = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: rtl/pc_interface_read_ctrl.sv
// Read controller: fetches one word from the read bank on request and streams it
// as a header / data / checksum byte frame over a valid/ready interface.
module pc_interface_read_ctrl
    import pc_interface_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = 16,
    parameter int unsigned              ADDR_WIDTH  = 3,
    parameter bit                       HEADER_EN   = 1'b1,
    parameter logic [PC_IF_BYTE_W-1:0]  HEADER_BYTE = PC_IF_HEADER_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic [ADDR_WIDTH-1:0]   o_bank_addr,
    input  logic [DATA_WIDTH-1:0]   i_bank_data,
    output logic [PC_IF_BYTE_W-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [PC_IF_BYTE_W-1:0] CHK_INIT = HEADER_EN ? HEADER_BYTE : '0;

    pc_if_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   bank_addr_q, bank_addr_d;
    logic [PC_IF_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    sh_load;
    logic                    sh_shift;
    logic [PC_IF_BYTE_W-1:0] sh_byte;
    logic [PC_IF_BYTE_W-1:0] sh_next_byte;
    logic [PC_IF_BYTE_W-1:0] sh_chk_next;
    logic                    sh_last;

    pc_interface_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_shift (
        .clk_i       (i_clk),
        .arst_n_i    (i_arst_n),
        .load_i      (sh_load),
        .word_i      (i_bank_data),
        .chk_init_i  (CHK_INIT),
        .shift_i     (sh_shift),
        .byte_o      (sh_byte),
        .next_byte_o (sh_next_byte),
        .chk_next_o  (sh_chk_next),
        .last_o      (sh_last)
    );

    assign accept = tx_valid_q & i_tx_ready;

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d     = state_q;
        bank_addr_d = bank_addr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        done_d      = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    bank_addr_d = i_req_addr;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sh_load    = 1'b1;
                tx_valid_d = 1'b1;
                if (HEADER_EN) begin
                    tx_data_d = HEADER_BYTE;
                    state_d   = ST_HEADER;
                end else begin
                    tx_data_d = sh_next_byte;
                    state_d   = ST_DATA;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    tx_data_d = sh_byte;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        tx_data_d = sh_chk_next;
                        state_d   = ST_CHKSUM;
                    end else begin
                        tx_data_d = sh_next_byte;
                    end
                end
            end
            ST_CHKSUM: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            bank_addr_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_addr_q <= bank_addr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_bank_addr = bank_addr_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule
